beep_seq_ctrl: RTL and testbench
================================

# beep_seq_ctrl

Sequencer that drives the single-shot beep timer to play an on/off buzzer pattern: `on_len` cycles on, `off_len` cycles off, repeated `reps` times. It sits between the user/key logic and the beep timer. It owns the timer's `timetogo`/`countMode`/`countAct` inputs, consumes its `fullflag`, and produces the buzzer enable plus busy/done status.

## Interface
- `TW`, 32: width of the timer load value and of `on_len`/`off_len`.
- `RW`, 8: width of the repeat count.

- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a pattern; sampled only in IDLE.
- `stop`  in  1: abort; honoured in any state; wins over `start`.
- `on_len`  in  TW: ON phase length, in timer counts.
- `off_len`  in  TW: OFF phase length, in timer counts.
- `reps`  in  RW: number of ON/OFF pairs.
- `fullflag`  in  1: timer completion pulse, one cycle.
- `timetogo`  out  TW: timer load value.
- `countMode`  out  1: constant 0 (single-shot mode).
- `countAct`  out  1: one-cycle timer launch pulse.
- `buzz_en`  out  1: buzzer drive.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, LOAD_ON, WAIT_ON, LOAD_OFF, WAIT_OFF, DONE.
- **IDLE**
  - Behaviour on `start`=1 and `stop`=0: latch `on_len`, `off_len`, `reps` into internal registers, then go to LOAD_ON.
  - Exception: if `reps`=0, go to DONE instead; no beep occurs.
  - Input changes after the latch have no effect until the next start.
- **LOAD_ON** (1 cycle)
  - `buzz_en`=1.
  - If the latched on length is nonzero: `timetogo`=latched on length, `countAct`=1, go to WAIT_ON.
  - If it is zero: no launch, `buzz_en`=0, go to LOAD_OFF.
- **WAIT_ON**
  - `buzz_en`=1.
  - On `fullflag`=1, go to LOAD_OFF.
- **LOAD_OFF** (1 cycle)
  - `buzz_en`=0.
  - If the latched off length is nonzero: `timetogo`=latched off length, `countAct`=1, go to WAIT_OFF.
  - If it is zero, treat as end of pair (see below).
- **WAIT_OFF**
  - `buzz_en`=0.
  - On `fullflag`, end of pair.
- **End of pair**
  - Decrement the remaining-rep counter.
  - If the result is nonzero, go to LOAD_ON; else go to DONE.
- **DONE** (1 cycle): `done`=1, then IDLE.
- **`fullflag` filtering**
  - Ignored in IDLE, LOAD_*, DONE, and in the cycle the controller itself asserts `countAct`.
  - A stale pulse from an aborted run therefore never advances the FSM.
- **`stop`**
  - From any state, the next state is IDLE.
  - `buzz_en`, `countAct`, `done` are 0 from the next edge.
  - No `done` pulse is generated.
- **`start` while busy**: ignored; not queued.
- **`timetogo`**: holds its last driven value between launches.
- **Arithmetic**: unsigned; the rep counter is RW bits and is never decremented below 0.

## Timing
- **Reset values** (`rst`=0 at an edge): state IDLE, `timetogo`=0, `countMode`=0, `countAct`=0, `buzz_en`=0, `busy`=0, `done`=0; internal latches cleared.
- **Reset priority**: reset mid-pattern aborts exactly like `stop` and has priority over everything.
- **Outputs** are registered and change only on the clock edge after the state decision.
- **Start latency**: `start` at edge T gives LOAD_ON at T+1, with `countAct`, `buzz_en`, `busy` high in the cycle after T.
- **Timer contract used by the bench**: `fullflag` pulses for one cycle exactly N cycles after the `countAct` cycle, where N=`timetogo`.
- **Per-pair timing** (N=`on_len`, M=`off_len`, both nonzero):
  - `buzz_en` is high for N+1 cycles, then low for M+1 cycles.
  - Each pair lasts N+M+2 cycles.
- **Zero-length phases**: each costs exactly one cycle (its LOAD state).
- **`done` timing**: `done` asserts 1 cycle after the final end-of-pair. `busy` falls in the same cycle `done` falls.
- **Throughput**: back-to-back start is possible the cycle after DONE.

## Test plan
- Reset, then `start` with on_len=10, off_len=5, reps=3 -> three `buzz_en` pulses of 11 cycles separated by 6-cycle gaps; `countAct` pulses 6 times with `timetogo` alternating 10/5; `done` pulse once; `busy` high for 3*17+1 cycles.
- `reps`=0 with `start` -> no `countAct`, `buzz_en` stays 0, `done` 1 cycle after start, `busy` high 1 cycle.
- `off_len`=0, on_len=4, reps=2 -> `buzz_en` high 5 cycles, low 1 cycle, high 5 cycles; only 2 `countAct` pulses.
- `stop` asserted in WAIT_ON of rep 2 (on_len=20, off_len=20, reps=4) -> IDLE next cycle, `buzz_en`=0, no `done`; the timer's late `fullflag` is ignored; a new `start` plays a full pattern.
- `start` pulsed repeatedly while busy, and `start`+`stop` in the same IDLE cycle -> no restart, no latch change; same-cycle pair leaves the block in IDLE.
- `rst`=0 mid-WAIT_OFF -> all outputs at reset values on the next edge; the pattern does not resume after `rst` returns to 1.

Source files
------------

// File: rtl/beep_seq_ctrl_if.sv
// beep_seq_ctrl_if: pattern request, status and beep-timer signals of the beep sequencer.
interface beep_seq_ctrl_if #(
    parameter int TW = 32,
    parameter int RW = 8
);
    logic          start;
    logic          stop;
    logic [TW-1:0] on_len;
    logic [TW-1:0] off_len;
    logic [RW-1:0] reps;
    logic          fullflag;
    logic [TW-1:0] timetogo;
    logic          countMode;
    logic          countAct;
    logic          buzz_en;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, on_len, off_len, reps, fullflag,
        input  timetogo, countMode, countAct, buzz_en, busy, done
    );

    modport slave (
        input  start, stop, on_len, off_len, reps, fullflag,
        output timetogo, countMode, countAct, buzz_en, busy, done
    );
endinterface

// File: rtl/beep_seq_ctrl.sv
// beep_seq_ctrl: plays reps ON/OFF buzzer pairs by launching a single-shot beep timer per phase.
module beep_seq_ctrl #(
    parameter int TW = 32,
    parameter int RW = 8
) (
    input logic           clk,
    input logic           rst,
    beep_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_ON, WAIT_ON, LOAD_OFF, WAIT_OFF, DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] on_q, on_d, off_q, off_d, timetogo_q, timetogo_d;
    logic [RW-1:0] rep_q, rep_d, rep_dec;
    logic          act_q, act_d, buzz_q, buzz_d, busy_q, busy_d, done_q, done_d;
    logic          pair_end;

    always_comb begin
        state_d  = state_q;
        on_d     = on_q;
        off_d    = off_q;
        rep_d    = rep_q;
        pair_end = 1'b0;
        rep_dec  = (rep_q != '0) ? rep_q - 1'b1 : '0;
        case (state_q)
            IDLE: if (bus.start && !bus.stop) begin
                on_d    = bus.on_len;
                off_d   = bus.off_len;
                rep_d   = bus.reps;
                state_d = (bus.reps == '0) ? DONE : LOAD_ON;
            end
            LOAD_ON:  state_d = (on_q != '0) ? WAIT_ON : LOAD_OFF;
            WAIT_ON:  if (bus.fullflag) state_d = LOAD_OFF;
            LOAD_OFF: if (off_q != '0) state_d = WAIT_OFF; else pair_end = 1'b1;
            WAIT_OFF: pair_end = bus.fullflag;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (pair_end) begin
            rep_d   = rep_dec;
            state_d = (rep_dec != '0) ? LOAD_ON : DONE;
        end
        if (bus.stop) state_d = IDLE;
        // outputs are decoded from the state being entered so they register alongside it
        act_d      = (state_d == LOAD_ON && on_d != '0) || (state_d == LOAD_OFF && off_d != '0);
        buzz_d     = (state_d == LOAD_ON && on_d != '0) || state_d == WAIT_ON;
        timetogo_d = act_d ? ((state_d == LOAD_ON) ? on_d : off_d) : timetogo_q;
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            on_q       <= '0;
            off_q      <= '0;
            rep_q      <= '0;
            timetogo_q <= '0;
            act_q      <= 1'b0;
            buzz_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            on_q       <= on_d;
            off_q      <= off_d;
            rep_q      <= rep_d;
            timetogo_q <= timetogo_d;
            act_q      <= act_d;
            buzz_q     <= buzz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.timetogo  = timetogo_q;
    assign bus.countMode = 1'b0;
    assign bus.countAct  = act_q;
    assign bus.buzz_en   = buzz_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_beep_seq_ctrl.sv
// tb_beep_seq_ctrl: directed and random patterns against a per-cycle expected-trace model,
// with a bench-side single-shot timer answering countAct.
module tb_beep_seq_ctrl;
    localparam int TW = 32;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    beep_seq_ctrl_if #(.TW(TW), .RW(RW)) bus ();
    beep_seq_ctrl #(.TW(TW), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic          buzz;
        logic          act;
        logic          busy;
        logic          done;
        logic [TW-1:0] ttg;
    } cyc_t;

    cyc_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            tmr = 0;
    logic [TW-1:0] exp_ttg = '0;
    logic          cur_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_cyc(input logic b, input logic a, input logic d, input int t);
        cyc_t c;
        c.buzz = b;
        c.act  = a;
        c.busy = 1'b1;
        c.done = d;
        c.ttg  = TW'(t);
        exp_q.push_back(c);
    endtask

    // Expected trace straight from the phase rules: a nonzero phase of length L lasts L+1
    // cycles with a launch in its first, a zero phase lasts one silent cycle, then one done cycle.
    task automatic push_pattern(input int n, input int m, input int r);
        for (int i = 0; i < r; i++) begin
            if (n > 0) begin
                add_cyc(1, 1, 0, n);
                for (int j = 0; j < n; j++) add_cyc(1, 0, 0, 0);
            end else add_cyc(0, 0, 0, 0);
            if (m > 0) begin
                add_cyc(0, 1, 0, m);
                for (int j = 0; j < m; j++) add_cyc(0, 0, 0, 0);
            end else add_cyc(0, 0, 0, 0);
        end
        add_cyc(0, 0, 1, 0);
    endtask

    task automatic step();
        cyc_t c;
        logic ff;
        @(posedge clk);
        #1;
        ff = 1'b0;
        if (bus.countAct) tmr = int'(bus.timetogo);
        else if (tmr > 0) begin
            tmr--;
            ff = (tmr == 0);
        end
        bus.fullflag = ff;
        c = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (c.act) exp_ttg = c.ttg;
        cur_busy = c.busy;
        check("buzz_en", 64'(bus.buzz_en), 64'(c.buzz));
        check("countAct", 64'(bus.countAct), 64'(c.act));
        check("busy", 64'(bus.busy), 64'(c.busy));
        check("done", 64'(bus.done), 64'(c.done));
        check("timetogo", 64'(bus.timetogo), 64'(exp_ttg));
        check("countMode", 64'(bus.countMode), 64'(0));
    endtask

    task automatic cyc(input logic s, input logic p, input logic r,
                       input logic [TW-1:0] n, input logic [TW-1:0] m, input logic [RW-1:0] k);
        rst         = r;
        bus.start   = s;
        bus.stop    = p;
        bus.on_len  = n;
        bus.off_len = m;
        bus.reps    = k;
        if (!r) begin
            exp_q.delete();
            exp_ttg = '0;
        end else if (p) exp_q.delete();
        else if (s && !cur_busy) push_pattern(int'(n), int'(m), int'(k));
        step();
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(0, 0, 1, $urandom, $urandom, RW'($urandom));
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.fullflag = 0;
        bus.on_len = '0; bus.off_len = '0; bus.reps = '0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 1, 10, 5, 3);
        idle(56);
        cyc(1, 0, 1, 7, 7, 0);
        idle(3);
        cyc(1, 0, 1, 4, 0, 2);
        idle(14);
        cyc(1, 0, 1, 20, 20, 4);
        idle(50);
        cyc(0, 1, 1, 1, 1, 1);
        idle(30);
        cyc(1, 0, 1, 3, 2, 2);
        idle(15);
        cyc(1, 0, 1, 5, 3, 2);
        for (int i = 0; i < 19; i++) cyc(1, 0, 1, $urandom, $urandom, RW'($urandom));
        idle(10);
        cyc(1, 1, 1, 6, 6, 2);
        idle(5);
        cyc(1, 0, 1, 3, 10, 3);
        idle(8);
        cyc(0, 0, 0, 1, 1, 1);
        idle(40);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 199) != 0,
                TW'($urandom_range(0, 6)), TW'($urandom_range(0, 6)), RW'($urandom_range(0, 3)));
        end
        idle(100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
